// File: rtl/mc10_vram_responder_pkg.sv
// ----------------------------------------------------------------------------
// mc10_pkg : shared FSM states, default decode constants and VDG bit positions
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mc10_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VFETCH = 3'd1,
    VCAP   = 3'd2,
    CRD    = 3'd3,
    CCAP   = 3'd4,
    CWR    = 3'd5
  } state_t;

  localparam logic [15:0] DEF_RAM_BASE  = 16'h4000;
  localparam logic [7:0]  DEF_MODE_PAGE = 8'hBF;

  localparam int MODE_AG    = 5;
  localparam int MODE_GM_HI = 4;
  localparam int MODE_GM_LO = 2;
  localparam int MODE_CSS   = 6;

  localparam int ATTR_AS  = 7;
  localparam int ATTR_INV = 6;

endpackage

`default_nettype wire

// File: rtl/mc10_vram_responder_if.sv
// ----------------------------------------------------------------------------
// mc10_vram_responder_if : CPU request/acknowledge bus into the VRAM responder
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mc10_vram_responder_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack
  );

endinterface

`default_nettype wire

// File: rtl/mc10_vram_responder_cpu_decode.sv
// ----------------------------------------------------------------------------
// mc10_cpu_decode : CPU address decode into RAM window, mode page or other
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc10_cpu_decode
  import mc10_pkg::*;
#(
  parameter int          RAM_AW    = 13,
  parameter logic [15:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [7:0]  MODE_PAGE = DEF_MODE_PAGE
) (
  input  logic [15:0]       addr,
  output logic              ram_hit,
  output logic              mode_hit,
  output logic [RAM_AW-1:0] offset
);

  logic [15:0] diff;

  // 16-bit wrap-around subtraction makes the window test a single compare
  assign diff     = addr - RAM_BASE;
  assign ram_hit  = ({16'd0, diff} < (32'd1 << RAM_AW));
  assign mode_hit = !ram_hit && (addr[15:8] == MODE_PAGE);
  assign offset   = diff[RAM_AW-1:0];

endmodule

`default_nettype wire

// File: rtl/mc10_vram_responder.sv
// ----------------------------------------------------------------------------
// mc10_vram_responder : VDG video fetch + CPU access arbiter for shared RAM
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc10_vram_responder
  import mc10_pkg::*;
#(
  parameter int          RAM_AW    = 13,
  parameter logic [15:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [7:0]  MODE_PAGE = DEF_MODE_PAGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [RAM_AW-1:0]     vdg_addr,
  output logic [7:0]            vdg_dd,
  output logic                  vdg_an_s,
  output logic                  vdg_inv,
  output logic                  vdg_an_g,
  output logic [2:0]            vdg_gm,
  output logic                  vdg_css,
  mc10_vram_responder_if.slave  cpu,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  state_t                       state;
  logic [RAM_AW-1:0]            last_addr;
  logic                         dirty;
  logic                         dirty_now;
  logic                         ack;
  logic [7:0]                   dout_hold;
  logic [MODE_CSS:MODE_GM_LO]   mode_q;
  logic                         ram_hit;
  logic                         mode_hit;
  logic [RAM_AW-1:0]            offset;

  mc10_cpu_decode #(
    .RAM_AW    (RAM_AW),
    .RAM_BASE  (RAM_BASE),
    .MODE_PAGE (MODE_PAGE)
  ) u_decode (
    .addr     (cpu.cpu_addr),
    .ram_hit  (ram_hit),
    .mode_hit (mode_hit),
    .offset   (offset)
  );

  // A change seen this very cycle counts, so an idle fetch starts without delay
  assign dirty_now = dirty || (vdg_addr != last_addr);

  assign vdg_an_g = mode_q[MODE_AG];
  assign vdg_gm   = mode_q[MODE_GM_HI:MODE_GM_LO];
  assign vdg_css  = mode_q[MODE_CSS];

  // RAM read data is only meaningful during CCAP; elsewhere show the held value
  assign cpu.cpu_dout = (state == CCAP) ? ram_rdata : dout_hold;
  assign cpu.cpu_ack  = ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_addr <= '1;
      dirty     <= 1'b1;
      vdg_dd    <= 8'h00;
      vdg_an_s  <= 1'b0;
      vdg_inv   <= 1'b0;
      mode_q    <= '0;
      dout_hold <= 8'h00;
      ack       <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= 8'h00;
    end else begin
      ack    <= 1'b0;
      ram_we <= 1'b0;
      dirty  <= dirty_now;
      case (state)
        IDLE: begin
          if (dirty_now) begin
            state     <= VFETCH;
            ram_addr  <= vdg_addr;
            last_addr <= vdg_addr;
            dirty     <= 1'b0;
          // A request still high during its own ack cycle is the old one
          end else if (cpu.cpu_req && !ack) begin
            if (ram_hit) begin
              ram_addr <= offset;
              if (cpu.cpu_we) begin
                state     <= CWR;
                ram_we    <= 1'b1;
                ram_wdata <= cpu.cpu_din;
                ack       <= 1'b1;
              end else begin
                state <= CRD;
              end
            end else begin
              ack <= 1'b1;
              if (cpu.cpu_we) begin
                if (mode_hit) begin
                  mode_q <= cpu.cpu_din[MODE_CSS:MODE_GM_LO];
                end
              end else begin
                dout_hold <= 8'hFF;
              end
            end
          end
        end
        VFETCH: state <= VCAP;
        VCAP: begin
          vdg_dd   <= ram_rdata;
          vdg_an_s <= ram_rdata[ATTR_AS];
          vdg_inv  <= ram_rdata[ATTR_INV];
          state    <= IDLE;
        end
        CRD: begin
          ack   <= 1'b1;
          state <= CCAP;
        end
        CCAP: begin
          dout_hold <= ram_rdata;
          state     <= IDLE;
        end
        CWR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mc10_vram_responder.md
Name: mc10_vram_responder

Overview:
- Serves the VDG's video-fetch interface (videoaddr out, dd in) from the shared single-port system RAM, and arbitrates that RAM against CPU accesses.
- Decodes the MC-10 per-character attribute bits: an_s = data bit 7, inv = data bit 6.
- Holds the CPU-written VDG mode latch (an_g, gm, css).
- Sits between the CPU bus decode, the RAM macro and the VDG wrapper.

Parameters:
- RAM_AW, 13, RAM word-address width (8 KB).
- RAM_BASE, 16'h4000, CPU address of RAM word 0.
- MODE_PAGE, 8'hBF, CPU address high byte that selects the mode latch (whole page, write-only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vdg_addr  in  13  VDG fetch address (videoaddr); may change on any cycle
- vdg_dd  out  8  fetched byte presented to the VDG
- vdg_an_s  out  1  vdg_dd[7] of the presented byte
- vdg_inv  out  1  vdg_dd[6] of the presented byte
- vdg_an_g  out  1  mode latch bit 5
- vdg_gm  out  3  mode latch bits 4:2
- vdg_css  out  1  mode latch bit 6
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  16  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data; valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- ram_addr  out  RAM_AW  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, registered, 1-cycle latency

Behaviour:
- Reset values: vdg_dd = 0, vdg_an_s = 0, vdg_inv = 0; mode latch = 0 (an_g = 0, gm = 0, css = 0); cpu_dout = 0; cpu_ack = 0; ram_we = 0; ram_addr = 0; FSM in IDLE. Internal last_addr = 13'h1FFF and a dirty flag set to 1, so the first VDG fetch is forced after reset.
- Change detect: dirty is set when vdg_addr != last_addr. dirty is set by any address change, including a change during a fetch; in that case the fetch completes and a refetch is queued.
- CPU decode:
  - RAM hit: cpu_addr - RAM_BASE < 2^RAM_AW, unsigned, 16-bit wrap.
  - Mode hit: cpu_addr[15:8] == MODE_PAGE.
  - Anything else: acked in 1 cycle with no side effects; reads return 8'hFF.
  - Mode writes: latch cpu_din[6:2] and ack in 1 cycle; no RAM use.
  - Mode reads: return 8'hFF.
- FSM states: IDLE, VFETCH, VCAP, CRD, CCAP, CWR.
- IDLE:
  - dirty: go to VFETCH, drive ram_addr = vdg_addr, set last_addr = vdg_addr, clear dirty. VDG has priority.
  - Else cpu_req on a RAM hit with !cpu_we: go to CRD.
  - Else cpu_req on a RAM hit with cpu_we: go to CWR.
  - Other cpu_req: ack directly from IDLE.
- VFETCH to VCAP: VCAP registers ram_rdata into vdg_dd, vdg_an_s and vdg_inv (all three update in the same cycle), then returns to IDLE.
- CRD to CCAP: CCAP puts ram_rdata on cpu_dout and pulses cpu_ack, then returns to IDLE.
- CWR: ram_we = 1 for exactly one cycle with ram_wdata = cpu_din; cpu_ack pulses the same cycle; then IDLE.
- Latency:
  - VDG: new vdg_addr to updated vdg_dd is 3 cycles when idle. It is at most 6 cycles if a CPU read has just started (CRD + CCAP + IDLE + VFETCH + VCAP).
  - CPU: read ack 2 cycles after grant; write ack 1 cycle after grant.
- No CPU preemption: a CPU access in progress always completes. No VDG starvation: after any CPU ack the FSM returns to IDLE, where dirty wins.
- cpu_ack is never asserted on two consecutive cycles for the same request. The CPU must drop cpu_req or present a new request in the cycle after the ack; a held cpu_req is treated as a new request.
- Simultaneous CPU write and VDG fetch to the same address: the VDG is served first and sees the old byte. The CPU write does not re-dirty. The new value is seen only on the next address change.
- Asynchronous reset mid-operation aborts immediately. ram_we drops asynchronously with reset; no partial ack.

Decomposition:
- Shared package mc10_pkg:
  - FSM state enum.
  - Default RAM_BASE and MODE_PAGE constants.
  - Mode bit positions: AG = 5, GM = 4:2, CSS = 6.
  - Attribute bit positions: AS = 7, INV = 6.
- One natural sub-module, mc10_cpu_decode: combinational RAM/mode/other hit decode plus offset subtraction.
- Everything else stays in one file.

Test Plan:
- Reset release with RAM[0x1FFF] = 8'hC5 and vdg_addr = 13'h1FFF: a forced fetch completes within 3 cycles, giving vdg_dd = C5, vdg_an_s = 1, vdg_inv = 1.
- vdg_addr 0x0000 to 0x0001 with RAM[1] = 8'h3A and no CPU traffic: vdg_dd = 3A exactly 3 cycles later; an_s = 0, inv = 0.
- CPU read at 0x4010 (RAM[0x10] = 8'h77) issued 1 cycle before a vdg_addr change: the CPU gets cpu_dout = 77 with ack 2 cycles after grant, and the VDG update lands at 6 cycles or less.
- CPU write of 8'h5C to 0xBF00: vdg_an_g = 0, vdg_gm = 3'b111, vdg_css = 1, ack after 1 cycle, ram_we never asserted.
- Continuous cpu_req reads plus a vdg_addr change every 4 cycles: every VDG address is fetched, none skipped, and the CPU still receives acks.
- Assert reset_n low during CWR: ram_we = 0 immediately, no cpu_ack, and all outputs return to reset values.
